// File: rtl/gcd_job_ctrl.sv
// rtl/gcd_job_ctrl.sv - request FIFO, job issue FSM and result register for a sequential GCD core
module gcd_job_ctrl #(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int CYC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       core_load_o,
  output logic [W-1:0]               core_a_o,
  output logic [W-1:0]               core_b_o,
  input  logic [W-1:0]               core_gcd_i,
  input  logic                       core_done_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_gcd,
  output logic [TAG_W-1:0]           out_tag,
  output logic [CYC_W-1:0]           out_cycles,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       busy_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  logic [W-1:0]     mem_a   [DEPTH];
  logic [W-1:0]     mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  state_t           state_q;
  logic             core_load_q;
  logic [W-1:0]     core_a_q, core_b_q;
  logic [TAG_W-1:0] tag_q;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             out_valid_q;
  logic [W-1:0]     out_gcd_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [CYC_W-1:0] out_cycles_q;

  // in_ready decodes the registered count only, so a pop never frees a slot for the same cycle
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_LOAD);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= in_a;
      mem_b[wr_ptr_q]   <= in_b;
      mem_tag[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign cyc_d = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + CYC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_load_q  <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      tag_q        <= '0;
      cyc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_tag_q    <= '0;
      out_cycles_q <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          // holding off while a result is pending keeps results in request order
          if (count_q != '0 && !out_valid_q) begin
            state_q     <= S_LOAD;
            core_load_q <= 1'b1;
            core_a_q    <= mem_a[rd_ptr_q];
            core_b_q    <= mem_b[rd_ptr_q];
          end
        end
        S_LOAD: begin
          core_load_q <= 1'b0;
          tag_q       <= mem_tag[rd_ptr_q];
          cyc_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          cyc_q <= cyc_d;
          if (core_done_i) begin
            out_gcd_q    <= core_gcd_i;
            out_tag_q    <= tag_q;
            out_cycles_q <= cyc_d;
            out_valid_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          core_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_load_o  = core_load_q;
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign out_valid    = out_valid_q;
  assign out_gcd      = out_gcd_q;
  assign out_tag      = out_tag_q;
  assign out_cycles   = out_cycles_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != S_IDLE) | (count_q != '0) | out_valid_q;

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// tb/tb_gcd_job_ctrl.sv - self-checking bench for gcd_job_ctrl with a behavioural Euclid core
module tb_gcd_job_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        core_load_o;
  logic [31:0] core_a_o, core_b_o, core_gcd_i;
  logic        core_done_i;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_gcd;
  logic [3:0]  out_tag;
  logic [7:0]  out_cycles;
  logic [2:0]  fifo_count_o;
  logic        busy_o;

  gcd_job_ctrl #(.W(32), .TAG_W(4), .DEPTH(4), .CYC_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .core_load_o(core_load_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_gcd_i(core_gcd_i), .core_done_i(core_done_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_tag(out_tag),
    .out_cycles(out_cycles), .fifo_count_o(fifo_count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Euclid core: one remainder step per cycle, done while b==0, optional stall before stepping
  logic [31:0] c_a, c_b;
  logic        c_busy;
  int          c_stall;
  int          stall_cfg = 0;
  logic        stray_done = 1'b0;
  assign core_done_i = (c_busy && c_b == 0 && c_stall == 0) || stray_done;
  assign core_gcd_i  = c_a;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0; c_a <= '0; c_b <= '0; c_stall <= 0;
    end else if (core_load_o) begin
      c_busy <= 1'b1; c_a <= core_a_o; c_b <= core_b_o; c_stall <= stall_cfg;
    end else if (c_busy) begin
      if (c_stall > 0) c_stall <= c_stall - 1;
      else if (c_b == 0) c_busy <= 1'b0;
      else begin c_a <= c_b; c_b <= c_a % c_b; end
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] b; } job_t;
  typedef struct { logic [31:0] g; logic [3:0] tag; int cyc; } res_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  job_t issue_q[$];
  res_t res_q[$];
  int got_gcd[$], got_tag[$], got_cyc[$];
  int acc_cyc, load_cyc, rise_cyc, load_cnt = 0;
  logic [31:0] last_load_a, last_load_b;
  logic inflight = 1'b0;
  logic prev_ov = 1'b0, prev_hs = 1'b0, prev_load = 1'b0;
  logic [31:0] prev_gcd; logic [3:0] prev_tag; logic [7:0] prev_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input int stall);
    res_t r;
    logic [31:0] x, y, t;
    int k;
    x = a; y = b; k = 1 + stall;
    while (y != 0) begin t = x % y; x = y; y = t; k++; end
    r.g = x; r.tag = tag; r.cyc = (k > 255) ? 255 : k;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0; prev_hs = 1'b0; prev_load = 1'b0;
    end else begin
      chk("fifo_count", fifo_count_o, issue_q.size());
      chk("in_ready", in_ready, issue_q.size() < 4);
      chk("busy", busy_o, (issue_q.size() != 0) || inflight);
      if (out_valid && prev_ov && !prev_hs) begin
        chk("hold_gcd", out_gcd, prev_gcd);
        chk("hold_tag", out_tag, prev_tag);
        chk("hold_cycles", out_cycles, prev_cyc);
      end
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && res_q.size() == 0) chk("spurious_out_valid", 1, 0);
      if (out_valid && out_ready && res_q.size() != 0) begin
        res_t r;
        r = res_q.pop_front();
        chk("out_gcd", out_gcd, r.g);
        chk("out_tag", out_tag, r.tag);
        chk("out_cycles", out_cycles, r.cyc);
        got_gcd.push_back(int'(out_gcd));
        got_tag.push_back(int'(out_tag));
        got_cyc.push_back(int'(out_cycles));
        inflight = 1'b0;
      end
      if (core_load_o) begin
        if (issue_q.size() == 0 || prev_load || inflight) chk("unexpected_load", 1, 0);
        else begin
          job_t j;
          j = issue_q.pop_front();
          chk("core_a", core_a_o, j.a);
          chk("core_b", core_b_o, j.b);
        end
        load_cyc = cyc; load_cnt++; inflight = 1'b1;
        last_load_a = core_a_o; last_load_b = core_b_o;
      end
      if (in_valid && in_ready) begin
        issue_q.push_back('{a: in_a, b: in_b});
        res_q.push_back(model(in_a, in_b, in_tag, stall_cfg));
        acc_cyc = cyc;
      end
      prev_hs = out_valid && out_ready; prev_ov = out_valid; prev_load = core_load_o;
      prev_gcd = out_gcd; prev_tag = out_tag; prev_cyc = out_cycles;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got_gcd.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    if (got_gcd.size() < n) chk("result_timeout", got_gcd.size(), n);
  endtask

  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                            input int eg, input int ec, input int lat);
    int n;
    n = got_gcd.size();
    push(a, b, tag);
    wait_results(n + 1, 60);
    if (got_gcd.size() > n) begin
      chk("load_latency", load_cyc - acc_cyc, 2);
      chk("load_a", last_load_a, a);
      chk("load_b", last_load_b, b);
      chk("valid_latency", rise_cyc - acc_cyc, lat);
      chk("lit_gcd", got_gcd[n], eg);
      chk("lit_tag", got_tag[n], tag);
      chk("lit_cycles", got_cyc[n], ec);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    int base, lc;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_load", core_load_o, 0);
    chk("rst_core_a", core_a_o, 0);
    chk("rst_core_b", core_b_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", fifo_count_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b1;

    run_single(48, 18, 3, 6, 4, 7);
    run_single(7, 0, 5, 7, 1, 4);
    run_single(0, 5, 6, 5, 2, 5);
    run_single(0, 0, 7, 0, 1, 4);

    // fill: the first job issues immediately, so four pushes leave three queued
    out_ready = 1'b0;
    base = got_gcd.size(); lc = load_cnt;
    push(20, 15, 1); push(21, 14, 2); push(100, 75, 3); push(17, 5, 4);
    repeat (15) @(posedge clk); #1;
    chk("fill_count3", fifo_count_o, 3);
    chk("fill_ready3", in_ready, 1);
    chk("fill_one_issue", load_cnt - lc, 1);
    chk("fill_out_valid", out_valid, 1);
    push(6, 4, 5);
    chk("fill_count4", fifo_count_o, 4);
    chk("fill_ready_low", in_ready, 0);
    in_valid = 1'b1; in_a = 27; in_b = 18; in_tag = 6;
    repeat (5) @(posedge clk); #1;
    chk("full_no_write", fifo_count_o, 4);
    out_ready = 1'b1;
    push(27, 18, 6);
    wait_results(base + 6, 200);
    if (got_gcd.size() >= base + 6) begin
      chk("fill_r0", got_gcd[base], 5);   chk("fill_r1", got_gcd[base+1], 7);
      chk("fill_r2", got_gcd[base+2], 25); chk("fill_r3", got_gcd[base+3], 1);
      chk("fill_r4", got_gcd[base+4], 2);  chk("fill_r5", got_gcd[base+5], 9);
      chk("fill_t5", got_tag[base+5], 6);
    end

    // order under toggling backpressure
    out_ready = 1'b0;
    base = got_gcd.size();
    push(12, 8, 1); push(8, 12, 2); push(35, 14, 3);
    for (int i = 0; i < 120 && got_gcd.size() < base + 3; i++) begin
      out_ready = (i % 3 == 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_results(base + 3, 20);
    if (got_gcd.size() >= base + 3) begin
      chk("bp_g0", got_gcd[base], 4); chk("bp_t0", got_tag[base], 1);
      chk("bp_g1", got_gcd[base+1], 4); chk("bp_t1", got_tag[base+1], 2);
      chk("bp_g2", got_gcd[base+2], 7); chk("bp_t2", got_tag[base+2], 3);
      chk("bp_c1", got_cyc[base+1], 4);
    end
    repeat (3) @(posedge clk); #1;

    // saturating iteration counter
    stall_cfg = 300;
    base = got_gcd.size();
    push(9, 3, 4);
    wait_results(base + 1, 400);
    if (got_gcd.size() > base) begin
      chk("sat_cycles", got_cyc[base], 255);
      chk("sat_gcd", got_gcd[base], 3);
    end
    repeat (3) @(posedge clk); #1;

    // reset in the middle of WAIT with two jobs queued
    stall_cfg = 20;
    lc = load_cnt;
    push(30, 12, 1); push(40, 16, 2); push(50, 20, 3);
    repeat (5) @(posedge clk); #1;
    chk("pre_rst_loads", load_cnt - lc, 1);
    chk("pre_rst_count", fifo_count_o, 2);
    rst = 1'b1;
    issue_q.delete(); res_q.delete(); inflight = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_count", fifo_count_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_load", core_load_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    lc = load_cnt;
    repeat (20) @(posedge clk); #1;
    chk("post_rst_no_load", load_cnt - lc, 0);
    stall_cfg = 0;
    base = got_gcd.size();
    push(10, 4, 9);
    wait_results(base + 1, 60);
    if (got_gcd.size() > base) begin
      chk("post_rst_gcd", got_gcd[base], 2);
      chk("post_rst_tag", got_tag[base], 9);
    end
    repeat (3) @(posedge clk); #1;

    // stray done while idle
    lc = load_cnt;
    stray_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_out_valid", out_valid, 0);
      chk("stray_busy", busy_o, 0);
    end
    @(posedge clk); #1; stray_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("stray_no_load", load_cnt - lc, 0);
    chk("stray_out_valid_after", out_valid, 0);
    run_single(81, 27, 2, 27, 2, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
